// File: rtl/foreground_vram_writer.sv
// -----------------------------------------------------------------------------
// foreground_vram_writer
//
// Host-side write port into the foreground plane's VRAM. The host issues
// commands over a valid/ready interface: kind=0 loads the address pointer and
// the auto-increment, and kind=1 queues a data write at the current pointer,
// then advances the pointer. Queued writes sit in a small circular FIFO. They
// drain into VRAM only on cycles where the plane's fetch logic grants a free
// slot.
//
// Handshake: a command transfers at a rising edge where I_wr_valid and
// O_wr_ready are both 1. O_wr_ready depends only on registered occupancy
// (plus reset), never on I_wr_valid or I_slot_free. The host holds the command
// stable until it transfers.
//
// Ports
//   I_pxl_clk    pixel clock, all logic on its rising edge
//   I_rst        synchronous active-high reset
//   I_wr_valid   host command valid
//   O_wr_ready   command accepted when valid and ready are both 1
//   I_wr_kind    0 = set address/increment, 1 = data write
//   I_wr_addr    new pointer value (kind=0)
//   I_wr_inc     new increment 0..15 (kind=0)
//   I_wr_data    write data (kind=1)
//   I_slot_free  VRAM write slot granted this cycle
//   O_vram_we    registered write enable, one pulse per drained entry
//   O_vram_addr  registered VRAM address
//   O_vram_din   registered VRAM data
//   O_level      FIFO occupancy
//   O_busy       FIFO non-empty or a write is being presented
// -----------------------------------------------------------------------------
module foreground_vram_writer #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst,
  input  logic              I_wr_valid,
  output logic              O_wr_ready,
  input  logic              I_wr_kind,
  input  logic [ADDR_W-1:0] I_wr_addr,
  input  logic [3:0]        I_wr_inc,
  input  logic [DATA_W-1:0] I_wr_data,
  input  logic              I_slot_free,
  output logic              O_vram_we,
  output logic [ADDR_W-1:0] O_vram_addr,
  output logic [DATA_W-1:0] O_vram_din,
  output logic [LVL_W-1:0]  O_level,
  output logic              O_busy
);

  localparam int IDX_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_W + DATA_W;

  // Address pointer state
  logic [ADDR_W-1:0] ptr;
  logic [3:0]        inc;

  // Circular buffer. The read/write pointers carry one extra bit, so
  // full and empty are told apart by the difference alone.
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [IDX_W:0]     wr_ptr;
  logic [IDX_W:0]     rd_ptr;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;

  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic             accept;
  logic             push;
  logic             pop;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == LVL_W'(FIFO_DEPTH));
  assign empty  = (level == '0);

  // A full FIFO refuses all commands, including address sets. A later
  // address set can then never overtake queued data. Ready is also low
  // during the reset cycle.
  assign O_wr_ready = !full && !I_rst;
  assign accept     = I_wr_valid && O_wr_ready;
  assign push       = accept && I_wr_kind;
  // No bypass: an empty FIFO never pops, even if it is pushed this edge.
  assign pop        = !empty && I_slot_free;

  assign O_level = level;
  assign O_busy  = !empty || O_vram_we;

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      ptr         <= '0;
      inc         <= 4'd1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      O_vram_we   <= 1'b0;
      O_vram_addr <= '0;
      O_vram_din  <= '0;
    end else begin
      if (accept) begin
        if (I_wr_kind) begin
          wr_ptr <= wr_ptr + 1'b1;
          ptr    <= ptr + ADDR_W'(inc);   // wraps modulo 2^ADDR_W
        end else begin
          ptr <= I_wr_addr;
          inc <= I_wr_inc;
        end
      end
      O_vram_we <= pop;
      if (pop) begin
        {O_vram_addr, O_vram_din} <= mem[rd_idx];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset. Reset clears the pointers, which makes the
  // old contents unreachable.
  always_ff @(posedge I_pxl_clk) begin
    if (!I_rst && push) begin
      mem[wr_idx] <= {ptr, I_wr_data};
    end
  end

endmodule

// File: tb/tb_foreground_vram_writer.sv
// -----------------------------------------------------------------------------
// tb_foreground_vram_writer
//
// Directed and randomized stimulus for foreground_vram_writer. A queue-based
// reference model predicts every output each cycle. Observed VRAM writes are
// also logged, so directed steps can check exact address/data sequences.
// -----------------------------------------------------------------------------
module tb_foreground_vram_writer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 3;
  localparam int E_W    = ADDR_W + DATA_W;

  logic              I_pxl_clk = 1'b0;
  logic              I_rst = 1'b0;
  logic              I_wr_valid = 1'b0;
  logic              O_wr_ready;
  logic              I_wr_kind = 1'b0;
  logic [ADDR_W-1:0] I_wr_addr = '0;
  logic [3:0]        I_wr_inc = '0;
  logic [DATA_W-1:0] I_wr_data = '0;
  logic              I_slot_free = 1'b0;
  logic              O_vram_we;
  logic [ADDR_W-1:0] O_vram_addr;
  logic [DATA_W-1:0] O_vram_din;
  logic [LVL_W-1:0]  O_level;
  logic              O_busy;

  foreground_vram_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .I_pxl_clk  (I_pxl_clk),
    .I_rst      (I_rst),
    .I_wr_valid (I_wr_valid),
    .O_wr_ready (O_wr_ready),
    .I_wr_kind  (I_wr_kind),
    .I_wr_addr  (I_wr_addr),
    .I_wr_inc   (I_wr_inc),
    .I_wr_data  (I_wr_data),
    .I_slot_free(I_slot_free),
    .O_vram_we  (O_vram_we),
    .O_vram_addr(O_vram_addr),
    .O_vram_din (O_vram_din),
    .O_level    (O_level),
    .O_busy     (O_busy)
  );

  // ---------------- clock ----------------
  always #5 I_pxl_clk = ~I_pxl_clk;

  // ---------------- reference model / scoreboard ----------------
  logic [E_W-1:0]    exp_q[$];      // writes accepted but not yet issued
  logic [E_W-1:0]    obs_q[$];      // writes seen on the VRAM port
  logic [ADDR_W-1:0] m_ptr;
  logic [3:0]        m_inc;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_din;
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("vram_we", 32'(O_vram_we), 32'(m_we));
    check("vram_addr", 32'(O_vram_addr), 32'(m_addr));
    check("vram_din", 32'(O_vram_din), 32'(m_din));
    check("level", 32'(O_level), 32'(exp_q.size()));
    check("busy", 32'(O_busy), 32'((exp_q.size() > 0) || m_we));
  endtask

  // One clock cycle. Inputs are driven 1 time unit after the previous edge.
  // Ready is checked before the edge, and the model is advanced after it.
  task automatic cycle(input logic v, input logic k, input logic [ADDR_W-1:0] a,
                       input logic [3:0] i, input logic [DATA_W-1:0] d,
                       input logic s, output logic acc);
    logic             pop;
    logic [E_W-1:0]   e;
    I_wr_valid = v; I_wr_kind = k; I_wr_addr = a; I_wr_inc = i;
    I_wr_data = d; I_slot_free = s;
    #1;
    check("ready", 32'(O_wr_ready), 32'(exp_q.size() < DEPTH));
    acc = v && (exp_q.size() < DEPTH);
    pop = (exp_q.size() > 0) && s;
    @(posedge I_pxl_clk);
    #1;
    cyc++;
    if (pop) begin
      e = exp_q.pop_front();
      m_we = 1'b1; m_addr = e[E_W-1:DATA_W]; m_din = e[DATA_W-1:0];
    end else begin
      m_we = 1'b0;
    end
    if (acc) begin
      if (k) begin
        exp_q.push_back({m_ptr, d});
        m_ptr = m_ptr + ADDR_W'(m_inc);
      end else begin
        m_ptr = a; m_inc = i;
      end
    end
    if (O_vram_we) obs_q.push_back({O_vram_addr, O_vram_din});
    check_outputs();
  endtask

  task automatic do_reset();
    I_rst = 1'b1; I_wr_valid = 1'b0; I_slot_free = 1'b1;
    #1;
    check("ready_in_reset", 32'(O_wr_ready), 32'd0);
    @(posedge I_pxl_clk);
    #1;
    I_rst = 1'b0;
    exp_q.delete();
    m_ptr = '0; m_inc = 4'd1; m_we = 1'b0; m_addr = '0; m_din = '0;
    check_outputs();
  endtask

  function automatic logic slot_of(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return cyc[0];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Holds a command valid until it transfers, bounded by a cycle budget.
  task automatic send(input logic k, input logic [ADDR_W-1:0] a, input logic [3:0] i,
                      input logic [DATA_W-1:0] d, input int slot_mode);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) cycle(1'b1, k, a, i, d, slot_of(slot_mode), acc);
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n, input logic s);
    logic acc;
    for (int t = 0; t < n; t++) cycle(1'b0, 1'b0, '0, '0, '0, s, acc);
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && (exp_q.size() > 0 || m_we); t++) idle(1, 1'b1);
    idle(1, 1'b1);
    check("drained_busy", 32'(O_busy), 32'd0);
  endtask

  task automatic check_obs(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (idx < obs_q.size()) check("obs_entry", 32'(obs_q[idx]), 32'({a, d}));
    else check("obs_missing", 32'(obs_q.size()), 32'(idx + 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    m_ptr = '0; m_inc = 4'd1; m_we = 1'b0; m_addr = '0; m_din = '0;
    repeat (2) @(posedge I_pxl_clk);
    #1;
    do_reset();

    // Basic sequential writes with the slot always free
    obs_q.delete();
    send(1'b0, 13'h0100, 4'd1, '0, 1);
    send(1'b1, '0, '0, 8'hAA, 1);
    send(1'b1, '0, '0, 8'hBB, 1);
    send(1'b1, '0, '0, 8'hCC, 1);
    drain();
    check("t1_count", 32'(obs_q.size()), 32'd3);
    check_obs(0, 13'h0100, 8'hAA);
    check_obs(1, 13'h0101, 8'hBB);
    check_obs(2, 13'h0102, 8'hCC);

    // Fill the FIFO with the slot withheld, then release it
    obs_q.delete();
    send(1'b0, 13'h0200, 4'd1, '0, 1);
    drain();
    obs_q.delete();
    for (int n = 0; n < 4; n++) send(1'b1, '0, '0, 8'(8'h10 + n), 0);
    cycle(1'b1, 1'b1, '0, '0, 8'h14, 1'b0, acc);   // fifth is refused
    check("full_ready", 32'(O_wr_ready), 32'd0);
    check("full_level", 32'(O_level), 32'd4);
    send(1'b1, '0, '0, 8'h14, 1);
    drain();
    check("t2_count", 32'(obs_q.size()), 32'd5);
    for (int n = 0; n < 5; n++) check_obs(n, 13'(13'h0200 + n), 8'(8'h10 + n));

    // Pointer wrap
    obs_q.delete();
    send(1'b0, 13'h1FFE, 4'd3, '0, 1);
    send(1'b1, '0, '0, 8'h11, 1);
    send(1'b1, '0, '0, 8'h22, 1);
    drain();
    check_obs(0, 13'h1FFE, 8'h11);
    check_obs(1, 13'h0001, 8'h22);

    // Fill mode, increment 0
    obs_q.delete();
    send(1'b0, 13'h0040, 4'd0, '0, 1);
    for (int n = 0; n < 3; n++) send(1'b1, '0, '0, 8'h55, 1);
    drain();
    check("t4_count", 32'(obs_q.size()), 32'd3);
    for (int n = 0; n < 3; n++) check_obs(n, 13'h0040, 8'h55);

    // Level 2, slot toggling, host pushing every cycle
    send(1'b0, 13'(13'h0800), 4'd1, '0, 1);
    drain();
    send(1'b1, '0, '0, 8'(8'($urandom)), 0);
    send(1'b1, '0, '0, 8'(8'($urandom)), 0);
    check("t5_level2", 32'(O_level), 32'd2);
    for (int n = 0; n < 24; n++) send(1'b1, '0, '0, 8'($urandom), 2);
    drain();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
            13'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom_range(0, 1)), acc);
    end
    drain();

    // Reset with entries queued
    send(1'b0, 13'h0300, 4'd2, '0, 1);
    drain();
    for (int n = 0; n < 3; n++) send(1'b1, '0, '0, 8'(8'hE0 + n), 0);
    check("t6_level3", 32'(O_level), 32'd3);
    obs_q.delete();
    do_reset();
    check("rst_we", 32'(O_vram_we), 32'd0);
    check("rst_level", 32'(O_level), 32'd0);
    idle(6, 1'b1);
    check("no_stale", 32'(obs_q.size()), 32'd0);
    send(1'b1, '0, '0, 8'h77, 1);
    drain();
    check("t6_count", 32'(obs_q.size()), 32'd1);
    check_obs(0, 13'h0000, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
